sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-master Wishbone arbiter in front of a single SDRAM controller port.
// Master 0 is the video fetch engine, master 1 is the host/writer. The
// owner keeps the bus for as long as it holds cyc. Ties out of IDLE go to
// the master that did not own the bus last. Ownership passes straight to
// a waiting master without an IDLE cycle in between.
//
// Optional build macro: SDRAM_ARB_WATCHDOG_EN
//   When defined, a 16-bit watchdog counts stalled strobe cycles. After
//   TIMEOUT of them it gives the owner a one-cycle err pulse.
//
// Ports
//   sys_clk, sys_rst     clock and synchronous active-high reset
//   m0_* / m1_*          Wishbone master ports (cyc, stb, we, adr, dat_ms,
//                        sel in; dat_sm, ack, err out)
//   s_*                  shared port to the SDRAM controller
//   grant                one-hot owner: 01 = m0, 10 = m1, 00 = none
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_ms,
  input  logic [3:0]  m0_sel,
  output logic [31:0] m0_dat_sm,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_ms,
  input  logic [3:0]  m1_sel,
  output logic [31:0] m1_dat_sm,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_ms,
  output logic [3:0]  s_sel,
  input  logic [31:0] s_dat_sm,
  input  logic        s_ack,
  input  logic        s_err,
  output logic [1:0]  grant
);

  // The state encoding is the one-hot grant value, so grant is the state register itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state;
  logic   last_owner;  // 0 = m0 owned last, 1 = m1 owned last
  logic   wd_pulse;

  assign grant = state;

  // Ownership FSM. last_owner is reset to m1 so that m0 wins the first tie.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && (!m1_cyc || last_owner)) begin
            state      <= OWN0;
            last_owner <= 1'b0;
          end else if (m1_cyc) begin
            state      <= OWN1;
            last_owner <= 1'b1;
          end
        end
        OWN0: begin
          if (!m0_cyc) begin
            if (m1_cyc) begin
              state      <= OWN1;
              last_owner <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        OWN1: begin
          if (!m1_cyc) begin
            if (m0_cyc) begin
              state      <= OWN0;
              last_owner <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);

  logic [15:0] wd_count;

  // The counter clears whenever the owner releases cyc, because that is the
  // only way the grant can change. The pulse is therefore raised only while
  // the owner is still holding the bus, so it can never reach the next owner.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_count <= '0;
      wd_pulse <= 1'b0;
    end else begin
      wd_pulse <= 1'b0;
      if (state == IDLE || !s_cyc || s_ack || s_err) begin
        wd_count <= '0;
      end else if (s_stb) begin
        if (wd_count == WdLast) begin
          wd_count <= '0;
          wd_pulse <= 1'b1;
        end else begin
          wd_count <= wd_count + 16'd1;
        end
      end
    end
  end
`else
  assign wd_pulse = 1'b0;
`endif

  // Bus mux and response routing. All of it is forced quiet while reset is
  // asserted, so nothing leaks out before the state register is known.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_ms  = '0;
    s_sel     = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m0_dat_sm = s_dat_sm;
    m1_dat_sm = s_dat_sm;
    if (!sys_rst) begin
      case (state)
        OWN0: begin
          s_cyc    = m0_cyc;
          s_stb    = m0_stb;
          s_we     = m0_we;
          s_adr    = m0_adr;
          s_dat_ms = m0_dat_ms;
          s_sel    = m0_sel;
          m0_ack   = s_ack;
          m0_err   = s_err | wd_pulse;
        end
        OWN1: begin
          s_cyc    = m1_cyc;
          s_stb    = m1_stb;
          s_we     = m1_we;
          s_adr    = m1_adr;
          s_dat_ms = m1_dat_ms;
          s_sel    = m1_sel;
          m1_ack   = s_ack;
          m1_err   = s_err | wd_pulse;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Self-checking bench for sdram_arbiter, built with TIMEOUT = 10.
// Inputs change 1 ns after a rising edge. Outputs are sampled on the
// following falling edge. The watchdog expectations follow the
// SDRAM_ARB_WATCHDOG_EN macro, so the bench works in either build.
module tb_sdram_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_arbiter #(.TIMEOUT(10)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_adr    (m0_adr),
    .m0_dat_ms (m0_dat_ms),
    .m0_sel    (m0_sel),
    .m0_dat_sm (m0_dat_sm),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_adr    (m1_adr),
    .m1_dat_ms (m1_dat_ms),
    .m1_sel    (m1_sel),
    .m1_dat_sm (m1_dat_sm),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_dat_sm  (s_dat_sm),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .grant     (grant)
  );

  // Moves to 1 ns after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat_ms = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat_ms = 0; m1_sel = 0;
    s_ack = 0; s_err = 0; s_dat_sm = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst = 1;
    tick();
    sys_rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst = 1;
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom;
    m1_cyc = 1; m1_stb = 1; m1_adr = $urandom;
    s_ack = 1; s_err = 1; s_dat_sm = $urandom;
    tick();
    @(negedge sys_clk);
    checks++;
    if (grant !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_grant: got %b expected 00", grant);
    end
    checks++;
    if ({s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel} !== '0) begin
      failures++; $display("[TB] FAIL reset_sbus: got cyc=%b stb=%b adr=%h expected all zero", s_cyc, s_stb, s_adr);
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_ackerr: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    checks++;
    if (m0_dat_sm !== s_dat_sm || m1_dat_sm !== s_dat_sm) begin
      failures++; $display("[TB] FAIL reset_dat: got %h/%h expected %h", m0_dat_sm, m1_dat_sm, s_dat_sm);
    end
    tick();
    sys_rst = 0;
    idle_inputs();
  endtask

  task automatic test_single();
    int acks = 0;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_0100; m0_sel = 4'hf;
    tick();
    @(negedge sys_clk);
    checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b1 || s_adr !== 32'h0000_0100) begin
      failures++; $display("[TB] FAIL single_grant: got grant=%b cyc=%b adr=%h expected 01 1 00000100", grant, s_cyc, s_adr);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      s_ack = (c == 3);
      s_dat_sm = (c == 3) ? 32'hDEAD_BEEF : $urandom;
      m0_cyc = (c < 4); m0_stb = (c < 4);
      @(negedge sys_clk);
      if (m0_ack) acks++;
      checks++;
      if (m1_ack !== 1'b0) begin
        failures++; $display("[TB] FAIL single_m1_ack: got %b expected 0", m1_ack);
      end
      if (c == 3) begin
        checks++;
        if (m0_ack !== 1'b1 || m0_dat_sm !== 32'hDEAD_BEEF) begin
          failures++; $display("[TB] FAIL single_data: got ack=%b dat=%h expected 1 deadbeef", m0_ack, m0_dat_sm);
        end
      end
    end
    checks++;
    if (acks != 1) begin
      failures++; $display("[TB] FAIL single_ack_count: got %0d expected 1", acks);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    @(negedge sys_clk);
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("[TB] FAIL tie_first: got %b expected 01", grant);
    end
    tick();
    m0_cyc = 0;
    tick();
    @(negedge sys_clk);
    checks++;
    if (grant !== 2'b10 || s_cyc !== 1'b1) begin
      failures++; $display("[TB] FAIL tie_handover: got grant=%b cyc=%b expected 10 1", grant, s_cyc);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_grant = 2'b01;
    do_reset();
    m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      checks++;
      if (grant !== exp_grant) begin
        failures++; $display("[TB] FAIL fair_grant%0d: got %b expected %b", i, grant, exp_grant);
      end
      tick();
      s_ack = 1;
      @(negedge sys_clk);
      checks++;
      if ({m1_ack, m0_ack} !== exp_grant) begin
        failures++; $display("[TB] FAIL fair_ack%0d: got %b expected %b", i, {m1_ack, m0_ack}, exp_grant);
      end
      tick();
      s_ack = 0;
      if (exp_grant == 2'b01) m0_cyc = 0; else m1_cyc = 0;
      tick();
      m0_cyc = 1; m1_cyc = 1;
      exp_grant = ~exp_grant;
    end
    idle_inputs();
  endtask

  task automatic test_no_preempt();
    int acks = 0;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = $urandom;
    tick();
    for (int beat = 0; beat < 8; beat++) begin
      s_ack = 1; s_dat_sm = $urandom;
      if (beat == 2) begin
        m0_cyc = 1; m0_stb = 1;
      end
      @(negedge sys_clk);
      if (m1_ack) acks++;
      checks++;
      if (grant !== 2'b10 || m0_ack !== 1'b0) begin
        failures++; $display("[TB] FAIL nopre_beat%0d: got grant=%b m0_ack=%b expected 10 0", beat, grant, m0_ack);
      end
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    @(negedge sys_clk);
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("[TB] FAIL nopre_release: got %b expected 01", grant);
    end
    checks++;
    if (acks != 8) begin
      failures++; $display("[TB] FAIL nopre_acks: got %0d expected 8", acks);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    tick();
    s_ack = 1;
    tick();
    @(negedge sys_clk);
    checks++;
    if (m0_ack !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_pre_ack: got %b expected 1", m0_ack);
    end
    tick();
    sys_rst = 1;
    tick();
    sys_rst = 0;
    @(negedge sys_clk);
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_after: got grant=%b cyc=%b ack=%b expected 00 0 0", grant, s_cyc, m0_ack);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_watchdog();
    logic exp_err;
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    tick();
    for (int c = 0; c < 16; c++) begin
`ifdef SDRAM_ARB_WATCHDOG_EN
      exp_err = (c == 10);
`else
      exp_err = 1'b0;
`endif
      @(negedge sys_clk);
      checks++;
      if (m1_err !== exp_err || m0_err !== 1'b0) begin
        failures++; $display("[TB] FAIL wd_cycle%0d: got m1_err=%b m0_err=%b expected %b 0", c, m1_err, m0_err, exp_err);
      end
      tick();
    end
    idle_inputs();
  endtask

  // Reference model: the owner keeps the bus while it holds cyc; otherwise
  // a lone requester takes it, and a tie goes to whoever did not own last.
  task automatic test_random();
    int owner = 0;  // 0 none, 1 m0, 2 m1
    int last  = 2;
    logic [1:0]  exp_grant;
    logic [70:0] exp_bus;
    logic [3:0]  exp_resp;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      m0_cyc = ($urandom_range(0, 3) != 0); m0_stb = $urandom_range(0, 1);
      m0_we = $urandom_range(0, 1); m0_adr = $urandom; m0_dat_ms = $urandom;
      m0_sel = 4'($urandom);
      m1_cyc = ($urandom_range(0, 3) != 0); m1_stb = $urandom_range(0, 1);
      m1_we = $urandom_range(0, 1); m1_adr = $urandom; m1_dat_ms = $urandom;
      m1_sel = 4'($urandom);
      s_ack = ($urandom_range(0, 3) != 0); s_err = ($urandom_range(0, 7) == 0);
      s_dat_sm = $urandom;
      exp_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      exp_bus = (owner == 1) ? {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel} :
                (owner == 2) ? {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel} : '0;
      exp_resp = {(owner == 1) & s_ack, (owner == 1) & s_err,
                  (owner == 2) & s_ack, (owner == 2) & s_err};
      @(negedge sys_clk);
      checks++;
      if (grant !== exp_grant) begin
        failures++; $display("[TB] FAIL rnd_grant%0d: got %b expected %b", n, grant, exp_grant);
      end
      checks++;
      if ({s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel} !== exp_bus) begin
        failures++; $display("[TB] FAIL rnd_bus%0d: got adr=%h expected adr=%h", n, s_adr, exp_bus[67:36]);
      end
      checks++;
      if ({m0_ack, m0_err, m1_ack, m1_err} !== exp_resp) begin
        failures++; $display("[TB] FAIL rnd_resp%0d: got %b expected %b", n, {m0_ack, m0_err, m1_ack, m1_err}, exp_resp);
      end
      checks++;
      if (m0_dat_sm !== s_dat_sm || m1_dat_sm !== s_dat_sm) begin
        failures++; $display("[TB] FAIL rnd_dat%0d: got %h/%h expected %h", n, m0_dat_sm, m1_dat_sm, s_dat_sm);
      end
      if (owner == 1 && m0_cyc) owner = 1;
      else if (owner == 2 && m1_cyc) owner = 2;
      else if (m0_cyc && m1_cyc) owner = (last == 1) ? 2 : 1;
      else if (m0_cyc) owner = 1;
      else if (m1_cyc) owner = 2;
      else owner = 0;
      if (owner != 0) last = owner;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    sys_rst = 1;
    idle_inputs();
    tick();
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_no_preempt();
    test_reset_midburst();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
